// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited memory requests, in-order prefetch FIFO, branch redirect.
// Optional feature macro FETCH_STALL_COUNT_EN adds the fd_stall_count starvation counter port.
module fetch_unit #(
  parameter int unsigned DEPTH        = 4,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD     = 32'hE1A0_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] fd_instruction,
  output logic [31:0] fd_pc,
  output logic        fd_valid,
  input  logic        de_ready,
  input  logic        de_branch_taken,
  input  logic [31:0] de_branch_target
`ifdef FETCH_STALL_COUNT_EN
  ,
  output logic [31:0] fd_stall_count
`endif
);

  localparam int unsigned   PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned   CW      = PW + 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1'b1);
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] stale_q, stale_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic          req_q, req_d;
  logic          valid_q, valid_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   fifo_data_q [DEPTH];
  logic [31:0]   fifo_pc_q   [DEPTH];

  logic          granted_s;
  logic          push_s;
  logic          pop_s;
  logic [CW-1:0] gnt_inc_s;
  logic [CW-1:0] rsp_dec_s;
  logic [CW-1:0] push_inc_s;
  logic [CW-1:0] pop_dec_s;
  logic [31:0]   head_data_s;
  logic [31:0]   head_pc_s;
  logic [31:0]   target_s;
  logic [1:0]    unused_tgt_s;

  assign target_s     = {de_branch_target[31:2], 2'b00};
  assign unused_tgt_s = de_branch_target[1:0];

  // Next-state: a redirect overrides push/pop; otherwise credit-limited fetch and FIFO update.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    resp_pc_d = resp_pc_q;
    stale_d   = stale_q;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    granted_s = req_q & mem_gnt;
    gnt_inc_s = granted_s ? CNT_ONE : '0;
    rsp_dec_s = mem_rvalid ? CNT_ONE : '0;
    out_d     = out_q + gnt_inc_s - rsp_dec_s;

    if (de_branch_taken) begin
      // Everything still in flight becomes stale and must be discarded on return.
      stale_d   = out_d;
      addr_d    = target_s;
      resp_pc_d = target_s;
      state_d   = (out_d != '0) ? S_DRAIN : S_FETCH;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_FETCH;
        end
        S_FETCH: begin
          addr_d    = granted_s ? (addr_q + 32'd4) : addr_q;
          push_s    = mem_rvalid;
          pop_s     = valid_q & de_ready;
          resp_pc_d = mem_rvalid ? (resp_pc_q + 32'd4) : resp_pc_q;
        end
        S_DRAIN: begin
          stale_d = stale_q - rsp_dec_s;
          state_d = (stale_d == '0) ? S_FETCH : S_DRAIN;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    push_inc_s = push_s ? CNT_ONE : '0;
    pop_dec_s  = pop_s ? CNT_ONE : '0;
    if (de_branch_taken) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
      wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      count_d  = count_q + push_inc_s - pop_dec_s;
    end

    req_d = (state_d == S_FETCH) && (({1'b0, count_d} + {1'b0, out_d}) < DEPTH_C);

    // The entry being written this edge is the new head only when the FIFO drains to it.
    if (push_s && (wr_ptr_q == rd_ptr_d)) begin
      head_data_s = mem_rdata;
      head_pc_s   = resp_pc_q;
    end else begin
      head_data_s = fifo_data_q[rd_ptr_d];
      head_pc_s   = fifo_pc_q[rd_ptr_d];
    end
    valid_d = (count_d != '0);
    instr_d = valid_d ? head_data_s : NOP_WORD;
    pc_d    = valid_d ? head_pc_s : 32'h0000_0000;
  end

  // State, counters, FIFO storage and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= RESET_VECTOR;
      resp_pc_q <= RESET_VECTOR;
      out_q     <= '0;
      stale_q   <= '0;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      instr_q   <= NOP_WORD;
      pc_q      <= 32'h0000_0000;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_data_q[i] <= 32'h0000_0000;
        fifo_pc_q[i]   <= 32'h0000_0000;
      end
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      resp_pc_q <= resp_pc_d;
      out_q     <= out_d;
      stale_q   <= stale_d;
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      req_q     <= req_d;
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      pc_q      <= pc_d;
      if (push_s) begin
        fifo_data_q[wr_ptr_q] <= mem_rdata;
        fifo_pc_q[wr_ptr_q]   <= resp_pc_q;
      end
    end
  end

  assign mem_req        = req_q;
  assign mem_addr       = addr_q;
  assign fd_valid       = valid_q;
  assign fd_instruction = instr_q;
  assign fd_pc          = pc_q;

`ifdef FETCH_STALL_COUNT_EN
  logic [31:0] stall_q, stall_d;

  // Saturating count of active cycles in which decode has nothing to consume.
  always_comb begin
    if ((state_q != S_IDLE) && !valid_q && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 32'h0000_0000;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign fd_stall_count = stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: in-order memory model plus an instruction-stream reference model.
module tb_fetch_unit;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RV    = 32'h0000_0000;
  localparam logic [31:0] NOP   = 32'hE1A0_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_rdata;
  logic [31:0] fd_instruction, fd_pc;
  logic        fd_valid, de_ready, de_branch_taken;
  logic [31:0] de_branch_target;
`ifdef FETCH_STALL_COUNT_EN
  logic [31:0] fd_stall_count;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.DEPTH(DEPTH), .RESET_VECTOR(RV), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .fd_instruction(fd_instruction), .fd_pc(fd_pc), .fd_valid(fd_valid),
    .de_ready(de_ready), .de_branch_taken(de_branch_taken), .de_branch_target(de_branch_target)
`ifdef FETCH_STALL_COUNT_EN
    , .fd_stall_count(fd_stall_count)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  // stimulus knobs
  int gnt_pct, ready_pct, br_pct, lat_min, lat_max;
  bit br_on_collision;
  int br_when_out;
  logic [31:0] br_tgt;
  bit br_done;
  int collisions;
  bit wrap_seen;
  int cyc = 0;

  // memory: in-order response queue
  typedef struct { logic [31:0] addr; int due; } resp_t;
  resp_t mem_q[$];

  // reference model: expected instruction stream and request credit
  logic [31:0] m_fifo[$];
  int          m_out, m_stale;
  logic [31:0] m_fetch, m_resp, m_stall;
  bit          m_idle;

  // inputs/outputs of the cycle that just ended
  bit          p_req, p_gnt, p_rv, p_br, p_ready;
  logic [31:0] p_addr, p_tgt;
  int          p_due;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  function automatic void model_reset();
    m_fifo.delete(); mem_q.delete();
    m_out = 0; m_stale = 0; m_fetch = RV; m_resp = RV; m_stall = 32'h0; m_idle = 1'b1;
    p_req = 1'b0; p_gnt = 1'b0; p_rv = 1'b0; p_br = 1'b0; p_ready = 1'b0;
    p_addr = 32'h0; p_tgt = 32'h0; p_due = 0;
  endfunction

  function automatic void model_update();
    bit exp_req   = !m_idle && (m_stale == 0) && (m_fifo.size() + m_out < DEPTH);
    bit was_valid = (m_fifo.size() != 0);
    bit granted   = exp_req && p_gnt;
    if (p_req && p_gnt) mem_q.push_back('{addr: p_addr, due: p_due});
    if (p_rv) void'(mem_q.pop_front());
    if (!m_idle && !was_valid && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
    m_idle = 1'b0;
    if (p_br) begin
      m_stale = m_out + int'(granted) - int'(p_rv);
      m_out   = m_stale;
      m_fifo.delete();
      m_fetch = {p_tgt[31:2], 2'b00};
      m_resp  = m_fetch;
    end else begin
      if (granted) begin m_out++; m_fetch = m_fetch + 32'd4; end
      if (was_valid && p_ready) void'(m_fifo.pop_front());
      if (p_rv) begin
        m_out--;
        if (m_stale > 0) m_stale--;
        else begin m_fifo.push_back(m_resp); m_resp = m_resp + 32'd4; end
      end
    end
  endfunction

  task automatic step();
    bit do_br, collide, exp_req, exp_valid;
    logic [31:0] exp_instr;
    @(negedge clk);
    cyc++;
    if (p_req && p_gnt && !p_br && p_addr == 32'hFFFF_FFFC && mem_addr == 32'h0) wrap_seen = 1'b1;
    model_update();
    exp_req   = !m_idle && (m_stale == 0) && (m_fifo.size() + m_out < DEPTH);
    exp_valid = (m_fifo.size() != 0);
    exp_instr = exp_valid ? word_of(m_fifo[0]) : NOP;
    vectors++; if (mem_req !== exp_req) begin miscompares++; $display("FAIL mem_req cyc=%0d got %b exp %b", cyc, mem_req, exp_req); end
    vectors++; if (mem_addr !== m_fetch) begin miscompares++; $display("FAIL mem_addr cyc=%0d got %h exp %h", cyc, mem_addr, m_fetch); end
    vectors++; if (fd_valid !== exp_valid) begin miscompares++; $display("FAIL fd_valid cyc=%0d got %b exp %b", cyc, fd_valid, exp_valid); end
    vectors++; if (fd_instruction !== exp_instr) begin miscompares++; $display("FAIL fd_instruction cyc=%0d got %h exp %h", cyc, fd_instruction, exp_instr); end
    if (exp_valid) begin
      vectors++; if (fd_pc !== m_fifo[0]) begin miscompares++; $display("FAIL fd_pc cyc=%0d got %h exp %h", cyc, fd_pc, m_fifo[0]); end
    end
`ifdef FETCH_STALL_COUNT_EN
    vectors++; if (fd_stall_count !== m_stall) begin miscompares++; $display("FAIL stall_count cyc=%0d got %0d exp %0d", cyc, fd_stall_count, m_stall); end
`endif
    do_br = 1'b0;
    if (br_when_out >= 0 && !m_idle && m_stale == 0 && m_out == br_when_out) begin
      do_br = 1'b1; br_when_out = -1; br_done = 1'b1;
    end
    mem_gnt  = !do_br && ($urandom_range(99) < gnt_pct);
    de_ready = ($urandom_range(99) < ready_pct);
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      mem_rvalid = 1'b1; mem_rdata = word_of(mem_q[0].addr);
    end else begin
      mem_rvalid = 1'b0; mem_rdata = $urandom();
    end
    collide = br_on_collision && mem_req && mem_gnt && mem_rvalid;
    if (collide) collisions++;
    de_branch_taken  = do_br || collide || ($urandom_range(99) < br_pct);
    de_branch_target = do_br ? br_tgt : $urandom();
    p_req = mem_req; p_gnt = mem_gnt; p_addr = mem_addr; p_rv = mem_rvalid;
    p_br = de_branch_taken; p_tgt = de_branch_target; p_ready = de_ready;
    p_due = cyc + int'($urandom_range(lat_max, lat_min));
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; de_ready = 1'b0;
    de_branch_taken = 1'b0; de_branch_target = 32'h0;
    br_when_out = -1; br_done = 1'b0; br_on_collision = 1'b0; br_pct = 0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
    vectors++; if (mem_addr !== RV) begin miscompares++; $display("FAIL reset_mem_addr got %h exp %h", mem_addr, RV); end
    vectors++; if (fd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_fd_valid got %b exp 0", fd_valid); end
    vectors++; if (fd_instruction !== NOP) begin miscompares++; $display("FAIL reset_fd_instruction got %h exp %h", fd_instruction, NOP); end
    vectors++; if (fd_pc !== 32'h0) begin miscompares++; $display("FAIL reset_fd_pc got %h exp 0", fd_pc); end
  endtask

  task automatic test_sequential();
    int first = -1;
    logic [31:0] gaddr[$];
    gnt_pct = 100; ready_pct = 100; lat_min = 1; lat_max = 1;
    apply_reset();
    for (int i = 1; i <= 40; i++) begin
      step();
      if (first < 0 && fd_valid === 1'b1) first = i;
      if (mem_req && mem_gnt) gaddr.push_back(mem_addr);
    end
    vectors++; if (first != 3) begin miscompares++; $display("FAIL first_valid_latency got %0d exp 3", first); end
    vectors++;
    if (gaddr.size() < 5 || {gaddr[0], gaddr[1], gaddr[2], gaddr[3], gaddr[4]} !==
        {32'd0, 32'd4, 32'd8, 32'd12, 32'd16}) begin
      miscompares++; $display("FAIL seq_addr got %0d grants, first %h exp 0,4,8,12,16", gaddr.size(), gaddr.size() > 0 ? gaddr[0] : 32'hX);
    end
  endtask

  task automatic test_backpressure();
    int grants = 0;
    bit seen = 1'b0;
    logic [31:0] first_addr = 32'hX;
    logic [31:0] pops[$];
    gnt_pct = 100; ready_pct = 0; lat_min = 1; lat_max = 3;
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      step();
      if (mem_req && mem_gnt) grants++;
    end
    vectors++; if (grants != DEPTH) begin miscompares++; $display("FAIL bp_grants got %0d exp %0d", grants, DEPTH); end
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL bp_req_low got %b exp 0", mem_req); end
    vectors++; if (fd_pc !== 32'h0) begin miscompares++; $display("FAIL bp_head_pc got %h exp 0", fd_pc); end
    ready_pct = 100;
    for (int i = 0; i < 30; i++) begin
      step();
      if (fd_valid && de_ready) pops.push_back(fd_pc);
      if (!seen && mem_req && mem_gnt) begin seen = 1'b1; first_addr = mem_addr; end
    end
    vectors++;
    if (pops.size() < 4 || {pops[0], pops[1], pops[2], pops[3]} !== {32'd0, 32'd4, 32'd8, 32'd12}) begin
      miscompares++; $display("FAIL bp_drain_order got %0d pops exp 0,4,8,12", pops.size());
    end
    vectors++; if (first_addr !== 32'd16) begin miscompares++; $display("FAIL bp_resume_addr got %h exp 00000010", first_addr); end
  endtask

  task automatic test_branch_drain();
    int n = 0;
    gnt_pct = 100; ready_pct = 100; lat_min = 3; lat_max = 3;
    apply_reset();
    br_when_out = 2; br_tgt = 32'h0000_0103;
    while (!br_done && n < 50) begin step(); n++; end
    vectors++; if (!br_done) begin miscompares++; $display("FAIL br_trigger got 0 exp 1"); end
    step();
    vectors++; if (mem_req !== 1'b0 || mem_addr !== 32'h100) begin
      miscompares++; $display("FAIL br_drain got req=%b addr=%h exp req=0 addr=00000100", mem_req, mem_addr);
    end
    n = 0;
    while (fd_valid !== 1'b1 && n < 30) begin step(); n++; end
    vectors++; if (fd_pc !== 32'h100 || fd_instruction !== word_of(32'h100)) begin
      miscompares++; $display("FAIL br_first_pc got %h/%h exp 00000100/%h", fd_pc, fd_instruction, word_of(32'h100));
    end
  endtask

  task automatic test_branch_collision();
    gnt_pct = 70; ready_pct = 60; lat_min = 1; lat_max = 2;
    apply_reset();
    collisions = 0; br_on_collision = 1'b1;
    repeat (300) step();
    br_on_collision = 1'b0;
    vectors++; if (collisions == 0) begin miscompares++; $display("FAIL collision_hits got 0 exp >0"); end
  endtask

  task automatic test_wrap();
    bit pc_wrap = 1'b0;
    logic [31:0] last = 32'h1;
    gnt_pct = 100; ready_pct = 100; lat_min = 1; lat_max = 2;
    apply_reset();
    wrap_seen = 1'b0; br_when_out = 0; br_tgt = 32'hFFFF_FFF2;
    for (int i = 0; i < 30; i++) begin
      step();
      if (fd_valid && de_ready) begin
        if (last == 32'hFFFF_FFFC && fd_pc == 32'h0) pc_wrap = 1'b1;
        last = fd_pc;
      end
    end
    vectors++; if (!wrap_seen) begin miscompares++; $display("FAIL addr_wrap got 0 exp 1"); end
    vectors++; if (!pc_wrap) begin miscompares++; $display("FAIL pc_wrap got 0 exp 1"); end
  endtask

  task automatic test_random();
    gnt_pct = 60; ready_pct = 60; lat_min = 1; lat_max = 4;
    apply_reset();
    br_pct = 4;
    repeat (1500) step();
    br_pct = 0;
  endtask

  task automatic test_reset_midrun();
    gnt_pct = 80; ready_pct = 50; lat_min = 1; lat_max = 3;
    apply_reset();
    repeat (40) step();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (mem_req !== 1'b0 || mem_addr !== RV || fd_valid !== 1'b0 || fd_instruction !== NOP) begin
      miscompares++; $display("FAIL midrun_reset got req=%b addr=%h valid=%b instr=%h", mem_req, mem_addr, fd_valid, fd_instruction);
    end
`ifdef FETCH_STALL_COUNT_EN
    vectors++; if (fd_stall_count !== 32'h0) begin miscompares++; $display("FAIL midrun_stall got %0d exp 0", fd_stall_count); end
`endif
    apply_reset();
    repeat (30) step();
  endtask

`ifdef FETCH_STALL_COUNT_EN
  task automatic test_stall_count();
    logic [31:0] prev;
    bit prev_valid;
    gnt_pct = 100; ready_pct = 100; lat_min = 5; lat_max = 5;
    apply_reset();
    br_when_out = 3; br_tgt = 32'h0000_0040;
    repeat (2) step();
    for (int i = 0; i < 80; i++) begin
      prev = fd_stall_count; prev_valid = (m_fifo.size() != 0);
      step();
      vectors++;
      if (fd_stall_count !== (prev_valid ? prev : prev + 32'd1)) begin
        miscompares++; $display("FAIL stall_step got %0d prev %0d valid %b", fd_stall_count, prev, prev_valid);
      end
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; de_ready = 1'b0;
    de_branch_taken = 1'b0; de_branch_target = 32'h0;
    br_when_out = -1; br_done = 1'b0; br_on_collision = 1'b0; br_pct = 0;
    collisions = 0; wrap_seen = 1'b0;
    model_reset();
    test_reset();
    test_sequential();
    test_backpressure();
    test_branch_drain();
    test_branch_collision();
    test_wrap();
    test_random();
    test_reset_midrun();
`ifdef FETCH_STALL_COUNT_EN
    test_stall_count();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that produces the fd_instruction stream consumed by the decode stage.
- Issues word-aligned read requests to instruction memory and buffers in-order responses in a small prefetch FIFO.
- Presents one instruction per accepted handshake to decode, together with its address.
- Redirects to a branch target on request from downstream, flushing buffered and in-flight instructions.

Parameters:
- DEPTH, 4, prefetch FIFO entries; power of two, 2..16.
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
- NOP_WORD, 32'hE1A0_0000, value driven on fd_instruction while fd_valid=0 (MOV R0,R0).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_req  out  1  read request to instruction memory.
- mem_addr  out  32  request address, bits [1:0] always 0.
- mem_gnt  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  read data valid; responses return in request order, at least 1 cycle after grant.
- mem_rdata  in  32  read data.
- fd_instruction  out  32  instruction at FIFO head.
- fd_pc  out  32  address of fd_instruction.
- fd_valid  out  1  head entry valid.
- de_ready  in  1  decode accepts head this cycle.
- de_branch_taken  in  1  redirect request, single-cycle pulse.
- de_branch_target  in  32  redirect address; bits [1:0] ignored.
- fd_stall_count  out  32  only with FETCH_STALL_COUNT_EN.

Behaviour:
- Reset (async assert, sync release): state=IDLE, mem_req=0, mem_addr=RESET_VECTOR, FIFO empty, fd_valid=0, fd_instruction=NOP_WORD, fd_pc=0, outstanding=0, stale=0.
- States and transitions:
  - IDLE: one cycle after reset release, then FETCH.
  - FETCH: normal operation, described below.
  - DRAIN: entered on a branch while any stale request is in flight.
- FETCH:
  - mem_req=1 iff fifo_count + outstanding < DEPTH (credit rule; FIFO can never overflow).
  - mem_addr is held stable until mem_gnt.
  - On mem_req & mem_gnt: mem_addr += 4, wrapping modulo 2^32, and outstanding += 1.
  - On mem_rvalid: push {mem_rdata, addr} into the FIFO and outstanding -= 1. The address is tracked by a response-order address counter.
- Output handshake:
  - fd_valid = FIFO not empty; fd_instruction and fd_pc come from the head entry.
  - Pop when fd_valid & de_ready.
  - Push and pop in the same cycle are allowed, including when the FIFO is full or empty-plus-push.
  - A response written at edge t is visible at t+1, so minimum response-to-fd_valid latency is 1 cycle. There is no bypass.
- Branch (de_branch_taken=1, any state), next edge:
  - FIFO cleared; fd_valid=0 next cycle. Any pop that cycle is ignored.
  - mem_addr = {de_branch_target[31:2], 2'b00}.
  - stale = outstanding, plus 1 if mem_req & mem_gnt in the branch cycle, minus 1 if mem_rvalid in the branch cycle.
  - outstanding is reset to the same value as stale.
  - If stale != 0, go to DRAIN; else go to FETCH.
  - A non-granted request pending in the branch cycle is withdrawn. The memory tolerates an address change before grant.
- DRAIN:
  - mem_req=0.
  - Each mem_rvalid decrements stale and outstanding and is discarded (not pushed).
  - When stale reaches 0, go to FETCH the next cycle.
  - A second branch in DRAIN updates the target only. stale keeps counting down.
- Simultaneous events: branch has priority over push and pop. A response in the branch cycle is discarded.
- Reset mid-operation: all state returns to reset values immediately. Late memory responses arriving after reset are the memory's responsibility; memory is reset together with this block.

Optional Feature:
- Macro: FETCH_STALL_COUNT_EN.
- Defined: fd_stall_count is a 32-bit counter, reset 0. It increments every cycle in FETCH or DRAIN with fd_valid=0, saturating at 32'hFFFF_FFFF.
- Not defined: the port is absent and no counter logic is synthesised.

Test Plan:
- Reset release, memory grants immediately with 1-cycle latency, de_ready=1 -> mem_addr sequence 0,4,8,..., first fd_valid 3 cycles after release, fd_pc tracks 0,4,8 with matching data.
- de_ready=0 held, DEPTH=4 -> exactly 4 grants, then mem_req=0; fd_pc=0 stays at head. Releasing de_ready drains 0,4,8,12 and fetching resumes at 16.
- Branch to 32'h0000_0103 with 2 requests in flight (3-cycle latency) -> DRAIN, 2 responses discarded, next mem_addr=32'h100, first fd_pc after branch=32'h100.
- Branch in the same cycle as mem_gnt and mem_rvalid -> stale count correct (granted counted, returning excluded), no stale data reaches fd_instruction.
- mem_addr=32'hFFFF_FFFC granted -> next mem_addr=32'h0000_0000; fd_pc wraps likewise.
- With FETCH_STALL_COUNT_EN, memory latency 5 and a branch -> fd_stall_count increments only while fd_valid=0; reset mid-run zeroes it and restarts fetch at RESET_VECTOR.
